// File: rtl/rv_enc_pkg.sv
// RV32I ALU-instruction field layout and encoding constants shared with the decoder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rv_enc_pkg;

  // Major opcodes for register-register and register-immediate ALU ops
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  // funct7 values: base form and the alternate form (SUB, SRA, SRAI)
  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  // funct3 values of the ALU group
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // 6-bit op field: itype selects OP-IMM, alt is funct7[5], rsvd must be zero
  typedef struct packed {
    logic       itype;
    logic       alt;
    logic       rsvd;
    logic [2:0] funct3;
  } op_t;

  // Shift ops carry a 5-bit shamt instead of a 12-bit immediate
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SR);
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Circular DEPTH x W FIFO with occupancy count and synchronous flush.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; full blocks refill even on a pop.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; left unreset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; reset and flush both return to empty
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded {op, rs1, rs2, rd, imm} into RV32I R/I-type words and queues them with a running byte address.
// Latency: one cycle from acceptance to out_valid when the queue is empty; one word per cycle sustained.
// Backpressure: in_ready = !full (registered, no same-cycle refill); head word and address hold while out_ready=0.
module instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int          DEPTH = 4,
  parameter logic [31:0] BASE  = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [5:0]             op,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  input  logic [4:0]             rd,
  input  logic [31:0]            imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_addr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);

  op_t         op_f;
  logic        shift_op;
  logic        alt_ok;
  logic        imm_ok;
  logic        legal;
  logic [6:0]  funct7;
  logic [31:0] word;
  logic        accept;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;

  assign op_f = op_t'(op);

  // Legality: reserved bit clear, alt form only where funct3 allows it, immediate in range
  always_comb begin
    shift_op = op_f.itype && is_shift_f3(op_f.funct3);
    alt_ok   = 1'b0;
    case (op_f.funct3)
      F3_ADD:  alt_ok = !op_f.itype;
      F3_SR:   alt_ok = 1'b1;
      F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_OR, F3_AND: alt_ok = 1'b0;
      default: alt_ok = 1'b0;
    endcase
    if (shift_op) begin
      imm_ok = (imm[31:5] == '0);
    end else begin
      imm_ok = (imm[31:11] == {21{imm[11]}});
    end
    legal = !op_f.rsvd && (!op_f.alt || alt_ok) && (!op_f.itype || imm_ok);
  end

  // Word packing for the three encodings
  always_comb begin
    funct7 = op_f.alt ? FUNCT7_ALT : FUNCT7_BASE;
    if (!op_f.itype) begin
      word = {funct7, rs2, rs1, op_f.funct3, rd, OPC_OP};
    end else if (shift_op) begin
      word = {funct7, imm[4:0], rs1, op_f.funct3, rd, OPC_OPIMM};
    end else begin
      word = {imm[11:0], rs1, op_f.funct3, rd, OPC_OPIMM};
    end
  end

  // Inputs presented during a flush are dropped, not accepted
  assign accept    = in_valid && in_ready && !flush;
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready;
  assign in_ready  = !full;
  assign out_valid = !empty;

  enc_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .wdata (word),
    .pop   (pop),
    .rdata (out_instr),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Sticky error on any accepted illegal input; only reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (accept && !legal) begin
      err <= 1'b1;
    end
  end

  // Byte address of the head word, advancing one word per pop
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_addr <= BASE;
    end else if (pop) begin
      out_addr <= out_addr + 32'd4;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors with hand-computed words.
// Latency: expects one cycle from acceptance to head.
// Backpressure: exercises full queue, stalled consumer and concurrent streaming.
module tb_instr_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  op;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [2:0]  count;
  logic        err;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] tb_addr;
  logic [31:0] first_addr;

  instr_encoder #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .count     (count),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one input, wait (bounded) for in_ready, record the expected word, cross the accept edge.
  // in_valid is left high so consecutive calls stream back to back.
  task automatic send(input logic [5:0] t_op, input logic [4:0] t_rs1, input logic [4:0] t_rs2,
                      input logic [4:0] t_rd, input logic [31:0] t_imm, input bit legal,
                      input logic [31:0] exp_instr);
    exp_t e;
    int   n;
    op = t_op; rs1 = t_rs1; rs2 = t_rs2; rd = t_rd; imm = t_imm;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stuck at 0, required 1 within 50 cycles");
      in_valid = 1'b0;
      return;
    end
    if (legal) begin
      e.instr = exp_instr;
      e.addr  = tb_addr;
      sb.push_back(e);
      tb_addr += 32'd4;
    end
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((count != 0 || sb.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_sb", 32'(sb.size()), 32'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && !flush && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got 0x%08h @0x%08h, required no word", out_instr, out_addr);
        end else begin
          e = sb.pop_front();
          chk("out_instr", out_instr, e.instr);
          chk("out_addr", out_addr, e.addr);
        end
      end
    end
  endtask

  function automatic logic [31:0] add_rd(input int k);
    return 32'h0020_8033 | (32'(k) << 7);
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
    tb_addr = BASE;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_out_addr", out_addr, BASE);

    // Basic ADD then SUB, one-cycle latency
    out_ready = 1'b1;
    send(6'h00, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 32'h0020_81B3);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_instr", out_instr, 32'h0020_81B3);
    send(6'h10, 5'd6, 5'd7, 5'd5, 32'd0, 1'b1, 32'h4073_02B3);
    chk("sub_instr", out_instr, 32'h4073_02B3);
    chk("sub_addr", out_addr, BASE + 32'd4);
    idle();

    // Immediates and shifts, including range edges
    send(6'h20, 5'd0, 5'd0, 5'd1, 32'hFFFF_FFFF, 1'b1, 32'hFFF0_0093);
    send(6'h35, 5'd2, 5'd0, 5'd2, 32'd3,         1'b1, 32'h4031_5113);
    send(6'h27, 5'd5, 5'd0, 5'd6, 32'd2047,      1'b1, 32'h7FF2_F313);
    send(6'h20, 5'd1, 5'd0, 5'd1, 32'hFFFF_F800, 1'b1, 32'h8000_8093);
    send(6'h21, 5'd3, 5'd0, 5'd4, 32'd31,        1'b1, 32'h01F1_9213);
    idle();
    wait_drain();

    // Illegal inputs: accepted, nothing queued, err sticks
    out_ready = 1'b0;
    send(6'h08, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'd0);
    chk("ill_rsvd_count", 32'(count), 32'd0);
    chk("ill_rsvd_err", 32'(err), 32'd1);
    send(6'h20, 5'd1, 5'd0, 5'd1, 32'd2048, 1'b0, 32'd0);
    chk("ill_imm_count", 32'(count), 32'd0);
    send(6'h35, 5'd2, 5'd0, 5'd2, 32'd32, 1'b0, 32'd0);
    chk("ill_shamt_count", 32'(count), 32'd0);
    send(6'h11, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'd0);
    chk("ill_alt_count", 32'(count), 32'd0);
    send(6'h00, 5'd1, 5'd2, 5'd9, 32'd0, 1'b1, add_rd(9));
    chk("legal_after_ill_count", 32'(count), 32'd1);
    // Illegal input while the head pops: only the pop happens
    out_ready = 1'b1;
    send(6'h08, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'd0);
    idle();
    chk("ill_pop_count", 32'(count), 32'd0);
    chk("err_sticky", 32'(err), 32'd1);

    // Full and backpressure
    out_ready  = 1'b0;
    first_addr = tb_addr;
    for (int k = 0; k < 4; k++) begin
      send(6'h00, 5'd1, 5'd2, 5'(10 + k), 32'd0, 1'b1, add_rd(10 + k));
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    op = 6'h00; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd14; imm = '0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_count", 32'(count), 32'd4);
      chk("stall_instr", out_instr, add_rd(10));
      chk("stall_addr", out_addr, first_addr);
    end
    out_ready = 1'b1;
    #1;
    chk("no_comb_ready", 32'(in_ready), 32'd0);
    send(6'h00, 5'd1, 5'd2, 5'd14, 32'd0, 1'b1, add_rd(14));
    idle();
    wait_drain();

    // Concurrent push/pop with pointer wrap, two words resident
    out_ready = 1'b0;
    send(6'h00, 5'd1, 5'd2, 5'd20, 32'd0, 1'b1, add_rd(20));
    send(6'h00, 5'd1, 5'd2, 5'd21, 32'd0, 1'b1, add_rd(21));
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(6'h00, 5'd1, 5'd2, 5'(i), 32'd0, 1'b1, add_rd(i));
      chk("stream_count", 32'(count), 32'd2);
    end
    idle();
    wait_drain();

    // Flush mid-stream, with an input presented in the flush cycle
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send(6'h00, 5'd1, 5'd2, 5'(k), 32'd0, 1'b1, add_rd(k));
    end
    chk("pre_flush_count", 32'(count), 32'd3);
    op = 6'h00; rd = 5'd30; in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    sb.delete();
    tb_addr = BASE;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_addr", out_addr, BASE);
    chk("flush_keeps_err", 32'(err), 32'd1);
    out_ready = 1'b1;
    send(6'h10, 5'd6, 5'd7, 5'd5, 32'd0, 1'b1, 32'h4073_02B3);
    idle();
    wait_drain();

    // Reset mid-stream
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send(6'h00, 5'd1, 5'd2, 5'(k + 4), 32'd0, 1'b1, add_rd(k + 4));
    end
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    tb_addr = BASE;
    chk("mrst_err", 32'(err), 32'd0);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_addr", out_addr, BASE);
    out_ready = 1'b1;
    send(6'h00, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 32'h0020_81B3);
    idle();
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
